contador_param: RTL

CONTADOR_PARAM -- requirements
Module: contador_param

---
 rtl/contador_param.sv | 96 +++++++++
 1 files changed

// File: rtl/contador_param.sv
// Parameterised modulo up/down counter with load clamp, wrap or saturate at the
// limits, a one-cycle terminal-count pulse and a sticky limit-event flag.
module contador_param #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_contador,
  input  logic             dir_cont,
  input  logic             modo_sat,
  input  logic             carga,
  input  logic [WIDTH-1:0] valor_carga,
  input  logic             limpa_flag,
  output logic [WIDTH-1:0] contagem_out,
  output logic             tc_out,
  output logic             overflow_flag
);

  // One extra bit keeps MODULO-1 and the +1 step representable when MODULO = 2**WIDTH.
  localparam logic [WIDTH:0] LIMIT_HI = (WIDTH + 1)'(MODULO - 1);
  localparam logic [WIDTH:0] ZERO_C   = {(WIDTH + 1){1'b0}};
  localparam logic [WIDTH:0] ONE_C    = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             flag_q, flag_d;

  logic [WIDTH:0]   cnt_ext_s;
  logic [WIDTH:0]   load_ext_s;
  logic [WIDTH:0]   next_ext_s;
  logic             limit_s;

  // Next-state logic: load beats counting; a limit event wraps or holds.
  always_comb begin
    cnt_ext_s  = {1'b0, count_q};
    load_ext_s = {1'b0, valor_carga};
    next_ext_s = cnt_ext_s;
    limit_s    = ~carga & enable_contador &
                 ((~dir_cont & (cnt_ext_s == LIMIT_HI)) |
                  ( dir_cont & (cnt_ext_s == ZERO_C)));

    if (carga) begin
      if (load_ext_s > LIMIT_HI) begin
        next_ext_s = LIMIT_HI;
      end else begin
        next_ext_s = load_ext_s;
      end
    end else if (enable_contador) begin
      if (limit_s) begin
        if (modo_sat) begin
          next_ext_s = cnt_ext_s;
        end else if (dir_cont) begin
          next_ext_s = LIMIT_HI;
        end else begin
          next_ext_s = ZERO_C;
        end
      end else if (dir_cont) begin
        next_ext_s = cnt_ext_s - ONE_C;
      end else begin
        next_ext_s = cnt_ext_s + ONE_C;
      end
    end else begin
      next_ext_s = cnt_ext_s;
    end

    count_d = next_ext_s[WIDTH-1:0];
    tc_d    = limit_s;

    if (limit_s) begin
      flag_d = 1'b1;
    end else if (limpa_flag) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // State registers; reset clears everything without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {WIDTH{1'b0}};
      tc_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      flag_q  <= flag_d;
    end
  end

  assign contagem_out  = count_q;
  assign tc_out        = tc_q;
  assign overflow_flag = flag_q;

endmodule
